// File: rtl/pdm_window_counter_if.sv
// pdm_window_counter_if: run control, PDM pins and density output of the window counter.
interface pdm_window_counter_if;
    logic       en;
    logic       pdm_data;
    logic       pdm_clk;
    logic [9:0] cntr;
    logic       cntr_valid;
    modport master(output en, pdm_data, input pdm_clk, cntr, cntr_valid);
    modport slave(input en, pdm_data, output pdm_clk, cntr, cntr_valid);
endinterface

// File: rtl/pdm_window_counter.sv
// pdm_window_counter: drives the PDM mic clock, counts ones per WINDOW samples.
// Define PDM_SYNC_EN to pass pdm_data through a 2-FF synchronizer (needs DIV >= 2).
module pdm_window_counter #(
    parameter int DIV    = 2,
    parameter int WINDOW = 1000
) (
    input logic clk,
    input logic rst,
    pdm_window_counter_if.slave bus
);
    localparam logic [7:0] PRE_LAST = 8'(DIV - 1);
    localparam logic [9:0] IDX_LAST = 10'(WINDOW - 1);
    logic [7:0] pre;
    logic [9:0] idx;
    logic [9:0] acc;
    logic       s;
    logic       wrap;
    logic       tick;
    logic       last;
`ifdef PDM_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], bus.pdm_data};
    end
    assign s = sync[1];
`else
    assign s = bus.pdm_data;
`endif
    // Sample on the last cycle of the high half, just before pdm_clk falls.
    always_comb begin
        wrap = pre == PRE_LAST;
        tick = bus.en && wrap && bus.pdm_clk;
        last = idx == IDX_LAST;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre            <= '0;
            idx            <= '0;
            acc            <= '0;
            bus.pdm_clk    <= 1'b0;
            bus.cntr       <= '0;
            bus.cntr_valid <= 1'b0;
        end else if (!bus.en) begin
            pre            <= '0;
            idx            <= '0;
            acc            <= '0;
            bus.pdm_clk    <= 1'b0;
            bus.cntr_valid <= 1'b0;
        end else begin
            pre            <= wrap ? '0 : pre + 8'd1;
            bus.pdm_clk    <= wrap ? ~bus.pdm_clk : bus.pdm_clk;
            bus.cntr_valid <= tick && last;
            if (tick) begin
                acc <= last ? '0 : acc + 10'(s);
                idx <= last ? '0 : idx + 10'd1;
                if (last) bus.cntr <= acc + 10'(s);
            end
        end
    end
endmodule

// File: tb/tb_pdm_window_counter.sv
// tb_pdm_window_counter: mic-model scoreboard for the default build plus a DIV=3/WINDOW=1023 instance.
module tb_pdm_window_counter;
    localparam int DIV = 2, W = 1000, DIV_B = 3, W_B = 1023;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pdm_window_counter_if a();
    pdm_window_counter_if b();
    pdm_window_counter #(.DIV(DIV), .WINDOW(W)) dut_a(.clk(clk), .rst(rst), .bus(a.slave));
    pdm_window_counter #(.DIV(DIV_B), .WINDOW(W_B)) dut_b(.clk(clk), .rst(rst), .bus(b.slave));

    int vectors = 0, miscompares = 0;
    int edges = 0, strobes = 0, nbit = 0, mode = 0, base = 0, held = 0;
    int acc_exp = 0;
    bit running = 1'b0;
    logic prev_clk = 1'b0, prev_valid = 1'b0;
    int cq[$];
    int eq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus patterns: 0 = all zeros, 1 = all ones, 2 = 4-of-5 / 1-of-5 alternating by window.
    function automatic logic pattern(input int j);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ((j / W) % 2 == 0) ? (j % 5 != 0) : (j % 5 == 0);
    endfunction

    // Mic model: a new bit is presented after each pdm_clk fall, stable through the next sample.
    task automatic drive_bit();
        logic d;
        d = pattern(nbit);
        a.pdm_data = d;
        acc_exp += int'(d);
        if (nbit % W == W - 1) begin
            cq.push_back(acc_exp);
            eq.push_back(base + 2 * DIV * W * (nbit / W + 1));
            acc_exp = 0;
        end
        nbit++;
    endtask

    task automatic start_run();
        nbit = 0;
        acc_exp = 0;
        base = edges;
        prev_clk = 1'b0;
        drive_bit();
        a.en = 1'b1;
        running = 1'b1;
    endtask

    task automatic stop_run();
        a.en = 1'b0;
        running = 1'b0;
        cq.delete();
        eq.delete();
    endtask

    task automatic cyc();
        int c, e;
        @(posedge clk);
        #1;
        edges++;
        if (a.cntr_valid) begin
            strobes++;
            check("valid_back_to_back", 32'(a.cntr_valid & prev_valid), 0);
            if (cq.size() == 0) check("spurious_strobe", 32'(a.cntr_valid), 0);
            else begin
                c = cq.pop_front();
                e = eq.pop_front();
                held = c;
                check("cntr", a.cntr, c);
                check("strobe_edge", edges, e);
            end
        end
        if (running && prev_clk && !a.pdm_clk) drive_bit();
        prev_clk = a.pdm_clk;
        prev_valid = a.cntr_valid;
    endtask

    task automatic wait_strobes(input int k);
        int target, i;
        target = strobes + k;
        i = 0;
        while (strobes < target && i < 2 * DIV * W * k + 100) begin
            cyc();
            i++;
        end
        check("strobe_count", strobes, target);
    endtask

    initial begin
        int i, n;
        a.en = 1'b0;
        a.pdm_data = 1'b0;
        b.en = 1'b0;
        b.pdm_data = 1'b1;
        repeat (3) cyc();
        check("rst_cntr", a.cntr, 0);
        check("rst_valid", a.cntr_valid, 0);
        check("rst_pdm_clk", a.pdm_clk, 0);
        rst = 1'b0;
        cyc();

        mode = 1; start_run(); wait_strobes(2);
        stop_run(); repeat (3) cyc();
        mode = 0; start_run(); wait_strobes(1);
        stop_run(); repeat (3) cyc();
        mode = 2; start_run(); wait_strobes(2);

        // Reset mid-window: window aborted, restart counts from release.
        stop_run(); mode = 1; start_run();
        repeat (1500) cyc();
        stop_run(); a.en = 1'b1;
        rst = 1'b1;
        cyc(); cyc();
        check("midrst_cntr", a.cntr, 0);
        check("midrst_valid", a.cntr_valid, 0);
        check("midrst_pdm_clk", a.pdm_clk, 0);
        held = 0;
        rst = 1'b0;
        start_run(); wait_strobes(1);

        // Drop en around idx 500, re-raise 10 cycles later.
        stop_run(); repeat (3) cyc();
        start_run();
        i = 0;
        while (nbit < 501 && i < 3000) begin cyc(); i++; end
        check("reach_idx500", nbit, 501);
        stop_run();
        repeat (10) begin
            cyc();
            check("idle_pdm_clk", a.pdm_clk, 0);
        end
        check("idle_cntr_held", a.cntr, held);
        start_run(); wait_strobes(1);

        // en falls in the very cycle of the window-end tick: IDLE wins, no strobe.
        stop_run(); repeat (3) cyc();
        start_run();
        while (edges < base + 2 * DIV * W - 1) cyc();
        stop_run();
        repeat (6) cyc();
        check("endtick_abort_valid", a.cntr_valid, 0);
        check("endtick_cntr_held", a.cntr, held);

        // DIV=3, WINDOW=1023, constant ones: clock shape, tick placement, full-scale count.
        @(posedge clk); #1;
        b.en = 1'b1;
        n = 0;
        check("b_pdm_clk_start", b.pdm_clk, 0);
        while (n < 7000) begin
            @(posedge clk); #1;
            n++;
            if (n < 30) begin
                check("b_pdm_clk", b.pdm_clk, (n / DIV_B) % 2);
                check("b_tick", dut_b.tick, n % (2 * DIV_B) == 2 * DIV_B - 1);
            end
            if (b.cntr_valid) break;
        end
        check("b_strobe_cycle", n, 2 * DIV_B * W_B);
        check("b_cntr", b.cntr, W_B);
        @(posedge clk); #1;
        check("b_valid_one_cycle", b.cntr_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pdm_window_counter.md
# pdm_window_counter

Front-end stage that drives a PDM microphone clock, samples the 1-bit PDM data stream and counts the ones over a fixed window of samples. Each completed window produces a 10-bit density value on `cntr`, with a one-cycle `cntr_valid` strobe. The `cntr`/`cntr_valid` pair feeds the `Top` packing stage directly, so a 50 % duty stream reads as WINDOW/2 and full-scale as WINDOW.

## Interface
- `DIV`, 2: clk cycles per pdm_clk half-period; legal range 1..255.
- `WINDOW`, 1000: PDM samples per output word; legal range 2..1023, so the count always fits 10 bits.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: one clock; reset is asynchronous and active-high.
- `en`  in  1: run enable; low holds the block idle.
- `pdm_data`  in  1: microphone PDM bit stream.
- `pdm_clk`  out  1: microphone clock, registered.
- `cntr`  out  10: ones count of the last completed window; held between strobes.
- `cntr_valid`  out  1: one-cycle strobe; `cntr` is new in this cycle.

## Operation
- Prescaler `pre` counts 0..DIV-1. On wrap, `pdm_clk` toggles. `tick` is the wrap cycle where `pdm_clk` is currently 1, i.e. the high-to-low transition.
- On `tick`, the sampled bit `s` (raw or synchronized `pdm_data`, see Configuration) is added to the 10-bit accumulator `acc`, and the sample index `idx` (0..WINDOW-1) advances.
- Window end: `tick` with `idx == WINDOW-1`:
  - `cntr <= acc + s`;
  - `cntr_valid <= 1` for exactly one cycle;
  - `acc <= 0`, `idx <= 0`.
- No saturation logic: `acc` never exceeds WINDOW-1 before the final add, and WINDOW ≤ 1023.
- States:
  - IDLE (`en` = 0): `pre`, `idx` and `acc` are forced to 0; `pdm_clk` is forced to 0; `cntr` holds; `cntr_valid` is 0.
  - RUN (`en` = 1): behaves as above.
  - IDLE→RUN on the first cycle `en` = 1. The first `pdm_clk` rise occurs DIV cycles later, and the window starts fresh at `idx` 0.
  - RUN→IDLE in the first cycle `en` = 0. The partial window is discarded and no strobe is issued. If this coincides with a window-end `tick`, IDLE wins: no strobe.
- Reset: `pdm_clk`=0, `cntr`=0, `cntr_valid`=0, `pre`=0, `idx`=0, `acc`=0. Asserting `rst` mid-window aborts the window immediately; no strobe is issued.

## Timing
- `pdm_clk` period: 2·DIV clk cycles; 50 % duty.
- `pdm_clk` is low for the first DIV cycles of RUN, then high.
- Sample point: the cycle in which `pdm_clk` is high and about to fall. Data has been stable since the rising edge, which matches microphones that drive on the rising edge.
- Window length: WINDOW·2·DIV clk cycles. Defaults give 4000 cycles between `cntr_valid` strobes.
- Latency: `cntr`/`cntr_valid` are registered and appear in the cycle after the final `tick`.
- `cntr_valid` is never high in two consecutive cycles. Minimum spacing is 2·WINDOW·DIV ≥ 4 cycles, which the downstream stage accepts without backpressure. There is no ready input.

## Configuration
- `PDM_SYNC_EN`, defined:
  - `pdm_data` passes through a 2-FF synchronizer clocked by `clk`, and `s` is the second flop. This adds 2 cycles of sampling latency relative to the pin.
  - Requires DIV ≥ 2 so the synchronized bit is settled by the sample point.
  - Synchronizer flops reset to 0.
- `PDM_SYNC_EN`, undefined: `s` = `pdm_data` directly. This is for simulation and for boards where the data pin is already registered in the pad.

## Test plan
- Reset: pulse `rst` for 2 cycles mid-run → `cntr`=0, `cntr_valid`=0, `pdm_clk`=0; the next strobe arrives a full 4000 cycles after `rst` release with `en`=1.
- Constant `pdm_data`=1, defaults → strobe every 4000 cycles with `cntr`=1000; with `pdm_data`=0 → `cntr`=0.
- Pattern with 4 ones per 5 samples, then 1 one per 5 samples → alternating windows give `cntr`=800, then 200.
- `pdm_clk` check, DIV=3 → period 6 cycles; low for 3 cycles after `en` rises; exactly 1 `tick` per period, in the cycle before the high-to-low transition.
- Drop `en` at `idx`=500, re-raise 10 cycles later with `pdm_data`=1 → no strobe for the aborted window; the next strobe shows `cntr`=1000 at 4000 cycles after `en` rose.
- WINDOW=1023, `pdm_data`=1 → `cntr`=1023 with no wrap. Repeat with `PDM_SYNC_EN` defined: same values; strobe timing unchanged relative to `en`.
